// File: rtl/panda_data_mem_responder_if.sv
// Data-memory port between the core's load/store unit (master) and the
// on-chip data-memory responder (slave).
interface panda_data_mem_responder_if;
  logic        data_req_i;
  logic        data_gnt_o;
  logic [31:0] data_addr_i;
  logic [3:0]  data_we_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  modport master (
    output data_req_i, data_addr_i, data_we_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_addr_i, data_we_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );
endinterface

// File: rtl/panda_data_mem_responder.sv
// Data-memory responder: word array with byte-lane writes and full-word reads after LATENCY cycles.
// Optional address range checking is enabled by defining PANDA_DMEM_RANGE_CHECK_EN.
module panda_data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  panda_data_mem_responder_if.slave   dmem
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned WAIT_INIT = (LATENCY > 1) ? (LATENCY - 2) : 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        mem [DEPTH];

  logic               gnt_c;
  logic               accept_c;
  logic               is_write_c;
  logic               access_ok_c;
  logic [ADDR_WIDTH-1:0] idx_c;
  logic [31:0]        fresh_data_c;
  logic               fresh_err_c;

  logic [31:0]        hold_data_q;
  logic               hold_err_q;
  logic               rvalid_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  logic               unused_addr_bits;

  assign idx_c            = dmem.data_addr_i[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{dmem.data_addr_i[31:ADDR_WIDTH+2], dmem.data_addr_i[1:0]};
  assign is_write_c       = (dmem.data_we_i != 4'b0000);

  // Grant is purely a function of state so the initiator can see it before raising req.
  assign gnt_c    = (state_q != WAIT);
  assign accept_c = dmem.data_req_i && gnt_c;

`ifdef PANDA_DMEM_RANGE_CHECK_EN
  localparam logic [32:0] LIMIT_ADDR = 33'(BASE_ADDR) + 33'(4 * DEPTH);
  assign access_ok_c = (dmem.data_addr_i >= BASE_ADDR) &&
                       ({1'b0, dmem.data_addr_i} < LIMIT_ADDR);
  assign fresh_err_c = !access_ok_c;
`else
  assign access_ok_c = 1'b1;
  assign fresh_err_c = 1'b0;
`endif

  // Read data is sampled before any write at this edge; writes and errors respond with zero.
  assign fresh_data_c = (is_write_c || !access_ok_c) ? 32'h0 : mem[idx_c];

  // Word array, not reset; writes commit at the accept edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept_c && is_write_c && access_ok_c) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem.data_we_i[b]) begin
          mem[idx_c][8*b +: 8] <= dmem.data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // State and latency counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept_c) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_INIT);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding registers capture the response at accept; outputs load when entering RESP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_data_q <= 32'h0;
      hold_err_q  <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      if (accept_c) begin
        hold_data_q <= fresh_data_c;
        hold_err_q  <= fresh_err_c;
      end
      rvalid_q <= (state_d == RESP);
      if (state_d == RESP) begin
        rdata_q <= accept_c ? fresh_data_c : hold_data_q;
        err_q   <= accept_c ? fresh_err_c  : hold_err_q;
      end else begin
        err_q   <= 1'b0;
      end
    end
  end

  assign dmem.data_gnt_o    = gnt_c;
  assign dmem.data_rvalid_o = rvalid_q;
  assign dmem.data_rdata_o  = rdata_q;
  assign dmem.data_err_o    = err_q;

endmodule

// File: tb/tb_panda_data_mem_responder.sv
// Directed bench for panda_data_mem_responder at LATENCY 1, 3 and 4.
module tb_panda_data_mem_responder;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst1, rst3, rst4;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  panda_data_mem_responder_if i1 ();
  panda_data_mem_responder_if i3 ();
  panda_data_mem_responder_if i4 ();

  panda_data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1), .BASE_ADDR(BASE)) u1 (
    .clk_i(clk), .rst_i(rst1), .dmem(i1));
  panda_data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(3), .BASE_ADDR(BASE)) u3 (
    .clk_i(clk), .rst_i(rst3), .dmem(i3));
  panda_data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(4), .BASE_ADDR(BASE)) u4 (
    .clk_i(clk), .rst_i(rst4), .dmem(i4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic req, input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    i1.data_req_i = req; i1.data_addr_i = a; i1.data_we_i = we; i1.data_wdata_i = wd;
  endtask

  task automatic drv3(input logic req, input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    i3.data_req_i = req; i3.data_addr_i = a; i3.data_we_i = we; i3.data_wdata_i = wd;
  endtask

  task automatic drv4(input logic req, input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    i4.data_req_i = req; i4.data_addr_i = a; i4.data_we_i = we; i4.data_wdata_i = wd;
  endtask

  logic        rc_en;
  logic [31:0] exp_w0;

  initial begin
`ifdef PANDA_DMEM_RANGE_CHECK_EN
    rc_en = 1'b1;
`else
    rc_en = 1'b0;
`endif
    rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    drv1(1'b0, 32'h0, 4'h0, 32'h0);
    drv3(1'b0, 32'h0, 4'h0, 32'h0);
    drv4(1'b0, 32'h0, 4'h0, 32'h0);
    step(); step();
    rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;

    // Reset state
    chk("rst_rvalid", 32'(i1.data_rvalid_o), 32'd0);
    chk("rst_rdata",  i1.data_rdata_o, 32'h0);
    chk("rst_err",    32'(i1.data_err_o), 32'd0);
    chk("rst_gnt",    32'(i1.data_gnt_o), 32'd1);

    // LATENCY=1: write then read back-to-back
    drv1(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
    chk("l1_gnt_wr", 32'(i1.data_gnt_o), 32'd1);
    step();
    chk("l1_wr_rvalid", 32'(i1.data_rvalid_o), 32'd1);
    chk("l1_wr_rdata",  i1.data_rdata_o, 32'h0);
    chk("l1_gnt_rd",    32'(i1.data_gnt_o), 32'd1);
    drv1(1'b1, BASE + 32'h10, 4'h0, 32'h0);
    step();
    chk("l1_rd_rvalid", 32'(i1.data_rvalid_o), 32'd1);
    chk("l1_rd_rdata",  i1.data_rdata_o, 32'hDEAD_BEEF);
    drv1(1'b0, 32'h0, 4'h0, 32'h0);
    step();
    chk("l1_idle_rvalid", 32'(i1.data_rvalid_o), 32'd0);
    chk("l1_idle_hold",   i1.data_rdata_o, 32'hDEAD_BEEF);

    // Byte and half-word lanes
    drv1(1'b1, BASE + 32'h20, 4'hF, 32'h1122_3344);   step();
    drv1(1'b1, BASE + 32'h20, 4'b0100, 32'hAAAA_AAAA); step();
    drv1(1'b1, BASE + 32'h22, 4'b0011, 32'h5566_5566); step();
    drv1(1'b1, BASE + 32'h20, 4'h0, 32'h0);            step();
    chk("lanes_rdata", i1.data_rdata_o, 32'h11AA_5566);
    drv1(1'b0, 32'h0, 4'h0, 32'h0); step();

    // Out-of-range write aliases to word 0 unless range checking is on
    drv1(1'b1, BASE, 4'hF, 32'hCAFE_F00D); step();
    drv1(1'b1, BASE + 32'h1000, 4'hF, 32'h1234_5678); step();
    chk("oor_wr_err",   32'(i1.data_err_o), 32'(rc_en));
    chk("oor_wr_rdata", i1.data_rdata_o, 32'h0);
    drv1(1'b1, BASE, 4'h0, 32'h0); step();
    exp_w0 = rc_en ? 32'hCAFE_F00D : 32'h1234_5678;
    chk("w0_rdata", i1.data_rdata_o, exp_w0);
    chk("w0_err",   32'(i1.data_err_o), 32'd0);
    drv1(1'b1, BASE + 32'h1000, 4'h0, 32'h0); step();
    chk("oor_rd_err",   32'(i1.data_err_o), 32'(rc_en));
    chk("oor_rd_rdata", i1.data_rdata_o, rc_en ? 32'h0 : 32'h1234_5678);
    drv1(1'b0, 32'h0, 4'h0, 32'h0); step();
    chk("err_cleared", 32'(i1.data_err_o), 32'd0);

    // Asynchronous reset pulse mid-cycle while a response is showing
    drv1(1'b1, BASE + 32'h10, 4'h0, 32'h0); step();
    drv1(1'b0, 32'h0, 4'h0, 32'h0);
    chk("pre_rst_rvalid", 32'(i1.data_rvalid_o), 32'd1);
    #2 rst1 = 1'b1;
    #1;
    chk("async_rvalid", 32'(i1.data_rvalid_o), 32'd0);
    chk("async_rdata",  i1.data_rdata_o, 32'h0);
    chk("async_err",    32'(i1.data_err_o), 32'd0);
    chk("async_gnt",    32'(i1.data_gnt_o), 32'd1);
    #1 rst1 = 1'b0;
    step();
    chk("post_rst_rvalid", 32'(i1.data_rvalid_o), 32'd0);

    // LATENCY=3: write, then a held read request accepted twice
    drv3(1'b1, BASE + 32'h40, 4'hF, 32'h0BAD_CAFE);
    chk("l3_gnt_c0", 32'(i3.data_gnt_o), 32'd1);
    step();
    drv3(1'b0, 32'h0, 4'h0, 32'h0);
    chk("l3_gnt_c1",   32'(i3.data_gnt_o), 32'd0);
    chk("l3_rv_c1",    32'(i3.data_rvalid_o), 32'd0);
    step();
    chk("l3_gnt_c2",   32'(i3.data_gnt_o), 32'd0);
    step();
    chk("l3_wr_rv",    32'(i3.data_rvalid_o), 32'd1);
    chk("l3_wr_rdata", i3.data_rdata_o, 32'h0);
    chk("l3_gnt_c3",   32'(i3.data_gnt_o), 32'd1);
    drv3(1'b1, BASE + 32'h40, 4'h0, 32'h0);
    step();
    chk("l3_rd_gnt1",  32'(i3.data_gnt_o), 32'd0);
    chk("l3_rd_rv1",   32'(i3.data_rvalid_o), 32'd0);
    step();
    chk("l3_rd_gnt2",  32'(i3.data_gnt_o), 32'd0);
    step();
    chk("l3_rd_rv",    32'(i3.data_rvalid_o), 32'd1);
    chk("l3_rd_rdata", i3.data_rdata_o, 32'h0BAD_CAFE);
    chk("l3_rd_gnt3",  32'(i3.data_gnt_o), 32'd1);
    step();
    drv3(1'b0, 32'h0, 4'h0, 32'h0);
    chk("l3_2nd_gnt",  32'(i3.data_gnt_o), 32'd0);
    step(); step();
    chk("l3_2nd_rv",   32'(i3.data_rvalid_o), 32'd1);
    chk("l3_2nd_rd",   i3.data_rdata_o, 32'h0BAD_CAFE);
    step();
    chk("l3_idle_rv",  32'(i3.data_rvalid_o), 32'd0);

    // LATENCY=4: reset during WAIT drops the response but keeps the write
    drv4(1'b1, BASE + 32'h80, 4'hF, 32'h600D_F00D);
    step();
    drv4(1'b0, 32'h0, 4'h0, 32'h0);
    chk("l4_wait_gnt", 32'(i4.data_gnt_o), 32'd0);
    #2 rst4 = 1'b1;
    #1;
    chk("l4_rst_gnt", 32'(i4.data_gnt_o), 32'd1);
    #1 rst4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("l4_no_rvalid", 32'(i4.data_rvalid_o), 32'd0);
    end
    drv4(1'b1, BASE + 32'h80, 4'h0, 32'h0);
    step();
    drv4(1'b0, 32'h0, 4'h0, 32'h0);
    step(); step();
    chk("l4_rv_early", 32'(i4.data_rvalid_o), 32'd0);
    step();
    chk("l4_rd_rv",    32'(i4.data_rvalid_o), 32'd1);
    chk("l4_rd_rdata", i4.data_rdata_o, 32'h600D_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
